// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin CPU/DMA arbiter for one data-memory port with a one-cycle response stage
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_req/a_we/a_size/a_unsigned/a_addr/a_wdata -> a_gnt/a_rvalid/a_err/a_rdata   CPU port
//   b_req/b_we/b_be/b_addr/b_wdata              -> b_gnt/b_rvalid/b_err/b_rdata   DMA port
//   mem_wmem/mem_rmem/mem_addr/mem_store_data -> memory, mem_load_data <- memory (one cycle after read)
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [1:0]            a_size,
  input  logic                  a_unsigned,
  input  logic [31:0]           a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic                  a_err,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [3:0]            b_be,
  input  logic [31:0]           b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic                  b_err,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [3:0]            mem_wmem,
  output logic [4:0]            mem_rmem,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_store_data,
  input  logic [DATA_WIDTH-1:0] mem_load_data
);
  localparam int HI = ADDR_WIDTH + 2;
  logic last_b;
  logic a_bad, b_bad, gnt, g_we, g_err;
  logic [3:0] a_wm;
  logic r_valid, r_owner, r_we, r_uns, r_err;
  logic [1:0] r_size, r_off;
  logic [7:0] lb;
  logic [15:0] hw;
  logic [DATA_WIDTH-1:0] ext;
  logic r_data_ok;
  logic unused_b_lsb;
  assign unused_b_lsb = &{1'b0, b_addr[1:0]};
  // last_b resets high so A wins the first contention
  assign a_gnt = rst_n & a_req & (~b_req | last_b);
  assign b_gnt = rst_n & b_req & ~a_gnt;
  assign gnt = a_gnt | b_gnt;
  assign a_bad = (|a_addr[31:HI]) | (a_size == 2'b11) | (a_size == 2'b01 & a_addr[0])
               | (a_size == 2'b10 & |a_addr[1:0]);
  assign b_bad = |b_addr[31:HI];
  assign g_we = a_gnt ? a_we : b_we;
  assign g_err = a_gnt ? a_bad : b_bad;
  assign a_wm = a_size == 2'b00 ? 4'b0001 << a_addr[1:0]
              : a_size == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mem_wmem = (gnt & g_we & ~g_err) ? (a_gnt ? a_wm : b_be) : 4'b0000;
  assign mem_rmem = {4'b0000, gnt & ~g_we & ~g_err};
  assign mem_addr = {{(32-ADDR_WIDTH){1'b0}}, a_gnt ? a_addr[HI-1:2] : b_addr[HI-1:2]};
  assign mem_store_data = ~a_gnt ? b_wdata
                        : a_size == 2'b00 ? {4{a_wdata[7:0]}}
                        : a_size == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b  <= 1'b1;
      r_valid <= 1'b0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_valid <= gnt;
      if (gnt) begin
        last_b  <= b_gnt;
        r_owner <= b_gnt;
        r_we    <= g_we;
        r_size  <= a_size;
        r_uns   <= a_unsigned;
        r_off   <= a_addr[1:0];
        r_err   <= g_err;
      end
    end
  end
  assign a_rvalid = r_valid & ~r_owner;
  assign b_rvalid = r_valid & r_owner;
  assign a_err = a_rvalid & r_err;
  assign b_err = b_rvalid & r_err;
  // writes and errors return zero data
  assign r_data_ok = ~r_we & ~r_err;
  assign lb = mem_load_data[8*r_off +: 8];
  assign hw = r_off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
  assign ext = r_size == 2'b00 ? {{24{~r_uns & lb[7]}}, lb}
             : r_size == 2'b01 ? {{16{~r_uns & hw[15]}}, hw} : mem_load_data;
  assign a_rdata = (a_rvalid & r_data_ok) ? ext : '0;
  assign b_rdata = (b_rvalid & r_data_ok) ? mem_load_data : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven bench with response scoreboard for dmem_arbiter
module tb_dmem_arbiter;
  logic clk, rst_n;
  logic a_req, a_we, a_unsigned, a_gnt, a_rvalid, a_err;
  logic [1:0] a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [3:0] b_be, mem_wmem;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [4:0] mem_rmem;
  logic [31:0] mem_addr, mem_store_data, mem_load_data;
  logic preload;
  logic [31:0] mem [256];
  int tests = 0, fails = 0;

  typedef struct {
    logic ar, awe; logic [1:0] asz; logic auns; logic [31:0] aaddr, awd;
    logic br, bwe; logic [3:0] bbe; logic [31:0] baddr, bwd;
    logic eag, ebg; logic [3:0] ewm; logic erm; logic [31:0] eaddr, esd;
    logic eerr; logic [31:0] erd;
  } vec_t;
  typedef struct { logic owner, err; logic [31:0] rd; } resp_t;
  resp_t q[$];
  vec_t tbl[19];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_unsigned(a_unsigned),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
    .mem_wmem(mem_wmem), .mem_rmem(mem_rmem), .mem_addr(mem_addr),
    .mem_store_data(mem_store_data), .mem_load_data(mem_load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 'h40) ? 32'h80F0_7F01 : 32'h0;
      mem_load_data <= 32'h0;
    end else begin
      if (mem_rmem[0]) mem_load_data <= mem[mem_addr[7:0]];
      for (int i = 0; i < 4; i++)
        if (mem_wmem[i]) mem[mem_addr[7:0]][i*8 +: 8] <= mem_store_data[i*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t va(logic we, logic [1:0] sz, logic uns, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] wm, logic rm, logic [31:0] ea, logic [31:0] esd,
                              logic err, logic [31:0] rd);
    vec_t v;
    v = idle();
    v.ar = 1; v.awe = we; v.asz = sz; v.auns = uns; v.aaddr = addr; v.awd = wd;
    v.eag = 1; v.ewm = wm; v.erm = rm; v.eaddr = ea; v.esd = esd; v.eerr = err; v.erd = rd;
    return v;
  endfunction

  function automatic vec_t vb(logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] wm, logic rm, logic [31:0] ea, logic err, logic [31:0] rd);
    vec_t v;
    v = idle();
    v.br = 1; v.bwe = we; v.bbe = be; v.baddr = addr; v.bwd = wd;
    v.ebg = 1; v.ewm = wm; v.erm = rm; v.eaddr = ea; v.esd = wd; v.eerr = err; v.erd = rd;
    return v;
  endfunction

  // both ports read: A word at 0x100, B word at 0x104
  function automatic vec_t both(logic a_wins);
    vec_t v;
    v = va(0, 2'b10, 0, 32'h100, 0, 4'b0, 1, 32'h40, 0, 0, 32'hA5F0_7F01);
    v.br = 1; v.baddr = 32'h104;
    v.eag = a_wins; v.ebg = ~a_wins;
    if (!a_wins) begin v.eaddr = 32'h41; v.erd = 32'h1234_0000; end
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_req = v.ar; a_we = v.awe; a_size = v.asz; a_unsigned = v.auns; a_addr = v.aaddr; a_wdata = v.awd;
    b_req = v.br; b_we = v.bwe; b_be = v.bbe; b_addr = v.baddr; b_wdata = v.bwd;
  endtask

  task automatic check_resp();
    resp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("a_rvalid", a_rvalid, !e.owner);
      chk("b_rvalid", b_rvalid, e.owner);
      chk("resp_err", e.owner ? b_err : a_err, e.err);
      chk("resp_rdata", e.owner ? b_rdata : a_rdata, e.rd);
      chk("other_rdata", e.owner ? a_rdata : b_rdata, 0);
    end else begin
      chk("idle_rvalid", {a_rvalid, b_rvalid}, 0);
      chk("idle_rdata", a_rdata | b_rdata, 0);
    end
  endtask

  task automatic run(input vec_t v);
    resp_t r;
    drive(v);
    @(negedge clk);
    check_resp();
    chk("a_gnt", a_gnt, v.eag);
    chk("b_gnt", b_gnt, v.ebg);
    chk("mem_wmem", mem_wmem, v.ewm);
    chk("mem_rmem", mem_rmem, {4'b0, v.erm});
    if ((v.eag || v.ebg) && !v.eerr) chk("mem_addr", mem_addr, v.eaddr);
    if (v.ewm != 0) chk("mem_store_data", mem_store_data, v.esd);
    if (v.eag || v.ebg) begin
      r.owner = v.ebg; r.err = v.eerr; r.rd = v.erd;
      q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = va(0, 2'b00, 0, 32'h102, 0, 4'b0, 1, 32'h40, 0, 0, 32'hFFFF_FFF0);
    tbl[1]  = va(0, 2'b00, 1, 32'h102, 0, 4'b0, 1, 32'h40, 0, 0, 32'h0000_00F0);
    tbl[2]  = va(0, 2'b01, 0, 32'h102, 0, 4'b0, 1, 32'h40, 0, 0, 32'hFFFF_80F0);
    tbl[3]  = va(0, 2'b01, 1, 32'h100, 0, 4'b0, 1, 32'h40, 0, 0, 32'h0000_7F01);
    tbl[4]  = va(0, 2'b10, 0, 32'h100, 0, 4'b0, 1, 32'h40, 0, 0, 32'h80F0_7F01);
    tbl[5]  = va(1, 2'b00, 0, 32'h103, 32'hA5, 4'b1000, 0, 32'h40, 32'hA5A5_A5A5, 0, 0);
    tbl[6]  = va(1, 2'b01, 0, 32'h106, 32'h1234, 4'b1100, 0, 32'h41, 32'h1234_1234, 0, 0);
    tbl[7]  = va(1, 2'b10, 0, 32'h108, 32'hDEAD_BEEF, 4'b1111, 0, 32'h42, 32'hDEAD_BEEF, 0, 0);
    tbl[8]  = vb(0, 4'b0000, 32'h101, 0, 4'b0, 1, 32'h40, 0, 32'hA5F0_7F01);
    tbl[9]  = vb(1, 4'b0101, 32'h10C, 32'h1122_3344, 4'b0101, 0, 32'h43, 0, 0);
    tbl[10] = vb(1, 4'b0000, 32'h10C, 32'h5566_7788, 4'b0000, 0, 32'h43, 0, 0);
    tbl[11] = va(0, 2'b10, 0, 32'h106, 0, 4'b0, 0, 0, 0, 1, 0);
    tbl[12] = va(0, 2'b01, 0, 32'h2_0001, 0, 4'b0, 0, 0, 0, 1, 0);
    tbl[13] = va(0, 2'b11, 0, 32'h100, 0, 4'b0, 0, 0, 0, 1, 0);
    tbl[14] = va(1, 2'b00, 0, 32'h2_0000, 32'h77, 4'b0, 0, 0, 0, 1, 0);
    tbl[15] = vb(0, 4'b0000, 32'h2_0000, 0, 4'b0, 0, 0, 1, 0);
    tbl[16] = idle();
    tbl[17] = vb(0, 4'b0000, 32'h10C, 0, 4'b0, 1, 32'h43, 0, 32'h0022_0044);
    tbl[18] = va(0, 2'b01, 1, 32'h106, 0, 4'b0, 1, 32'h41, 0, 0, 32'h0000_1234);
    preload = 1;
    rst_n = 0;
    drive(idle());
    a_req = 1; b_req = 1;
    @(posedge clk);
    #1;
    preload = 0;
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_mem_en", {mem_wmem, mem_rmem}, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid, a_err, b_err}, 0);
    drive(idle());
    rst_n = 1;
    for (int i = 0; i < 19; i++) run(tbl[i]);
    run(idle());
    rst_n = 0;
    #2;
    rst_n = 1;
    run(both(1));
    run(both(0));
    run(both(1));
    run(both(0));
    run(idle());
    drive(vb(0, 4'b0000, 32'h100, 0, 4'b0, 1, 32'h40, 0, 0));
    @(negedge clk);
    chk("rst_case_b_gnt", b_gnt, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    a_req = 1;
    #1;
    chk("rst_drop_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_hold_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_hold_mem", {mem_wmem, mem_rmem}, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    run(idle());
    run(idle());
    run(both(1));
    run(idle());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 15, giving the data-memory word-address width (2^15 words, 128 KiB).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the memory word width; only 32 is supported.
REQ-003 clk  in  1  sole clock; every register updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 a_req, a_we  in  1,1  CPU port request and write flag.
REQ-006 a_size  in  2  CPU access size: 00 byte, 01 half, 10 word; 11 illegal.
REQ-007 a_unsigned  in  1  zero-extend CPU loads (LBU/LHU) when 1; sign-extend when 0.
REQ-008 a_addr, a_wdata  in  32,32  CPU byte address and store data (right-aligned).
REQ-009 a_gnt, a_rvalid, a_err  out  1,1,1  CPU grant, response-valid pulse and error flag.
REQ-010 a_rdata  out  32  CPU load data, extended per a_size/a_unsigned.
REQ-011 b_req, b_we  in  1,1  DMA/loader port request and write flag.
REQ-012 b_be  in  4  DMA byte enables; b_addr  in  32  byte address, bits 1:0 ignored; b_wdata  in  32.
REQ-013 b_gnt, b_rvalid, b_err  out  1,1,1; b_rdata  out  32  raw memory word.
REQ-014 mem_wmem  out  4  memory byte write enables.
REQ-015 mem_rmem  out  5  memory read enable: 5'b00001 on a read access, zero otherwise.
REQ-016 mem_addr  out  32  word index: granted byte address bits [ADDR_WIDTH+1:2], zero-extended.
REQ-017 mem_store_data  out  32; mem_load_data  in  32, valid one cycle after the read access.

Function
REQ-018 Grant SHALL be combinational in cycle N; at most one of a_gnt/b_gnt SHALL be high per cycle, and a gnt SHALL only assert with its req.
REQ-019 With one requester active, that requester SHALL be granted; with both active, the requester not granted most recently SHALL win (round-robin pointer updated on every grant).
REQ-020 A granted, legal request SHALL drive mem_* in cycle N; back-to-back grants every cycle SHALL be supported.
REQ-021 CPU stores SHALL be formatted as follows: byte replicates a_wdata[7:0] to all lanes, mem_wmem = 1<<a_addr[1:0]; half replicates [15:0], mem_wmem = 0011 (a_addr[1]=0) or 1100; word, mem_wmem = 1111.
REQ-022 DMA stores SHALL pass b_wdata unchanged with mem_wmem = b_be; a DMA write with b_be = 0 SHALL still be granted and acknowledged.
REQ-023 A response stage SHALL register {valid, owner, we, size, unsigned, offset, err}; exactly one rvalid pulse SHALL go to the owner in cycle N+1 for every grant, for reads and writes alike.
REQ-024 A CPU read response SHALL select byte lane a_addr[1:0] or half lane a_addr[1] of mem_load_data and extend it to 32 bits.
REQ-025 A write response SHALL return rdata = 0.
REQ-026 A CPU request with a misaligned half (addr[0]=1), a misaligned word (addr[1:0]≠0) or a_size = 11 SHALL be an error.
REQ-027 Any request with byte address ≥ 2^(ADDR_WIDTH+2) SHALL be an error.
REQ-028 An error request SHALL still be granted, SHALL drive mem_wmem = 0 and mem_rmem = 0, and SHALL return rvalid with err = 1 and rdata = 0 in N+1.
REQ-029 With no grant, mem_wmem and mem_rmem SHALL be 0; mem_addr and mem_store_data are don't-care.
REQ-030 a_rdata/b_rdata SHALL be 0 whenever the matching rvalid is low.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear the response stage (all rvalid/err = 0) and set the round-robin pointer so that A wins the next contention.
REQ-032 While rst_n is low, all gnt outputs and mem_wmem/mem_rmem SHALL be 0.
REQ-033 A response pending when reset asserts SHALL be discarded, with no rvalid after deassertion.
REQ-034 Memory contents are outside this block and SHALL NOT be affected by reset.

Verification
REQ-035 A store byte 0xA5 to 0x103 -> mem_wmem=1000, mem_addr=0x40, mem_store_data=0xA5A5A5A5; a_rvalid=1 next cycle with err=0.
REQ-036 Memory word 0x80F0_7F01 at word 0x40: A loads byte 0x102 signed -> a_rdata=0xFFFFFFF0; unsigned -> 0x000000F0; A loads half 0x102 signed -> 0xFFFF80F0.
REQ-037 a_req and b_req held for 4 cycles after reset -> grants A,B,A,B; each rvalid one cycle after its grant.
REQ-038 A word load at 0x106 and a half load at 0x20001 -> granted, mem_rmem=0, a_rvalid with a_err=1, a_rdata=0.
REQ-039 B read granted, rst_n pulsed low in the following cycle -> no b_rvalid at any time after release; the next contention grants A.
